sseg_stopwatch: RTL and testbench
=================================

SSEG_STOPWATCH -- requirements
Module: sseg_stopwatch

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 5000000, meaning clk cycles per count step (10 Hz at 50 MHz); legal range 2 to 2^24.
REQ-002 The block SHALL have port clk, input, 1, rising-edge system clock.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 The block SHALL have port go, input, 1, single-cycle start/pause toggle pulse, synchronous to clk.
REQ-005 The block SHALL have port clr, input, 1, single-cycle clear pulse, synchronous to clk.
REQ-006 The block SHALL have port up, input, 1, count direction: 1 = up, 0 = down; sampled on every step.
REQ-007 The block SHALL have ports sseg0..sseg3, output, 8 each, active-low segment patterns for digits 0..3: bit7 dp, bits6..0 g,f,e,d,c,b,a; these feed the display multiplexer inputs in0..in3.
REQ-008 The block SHALL have port running, output, 1, high while in state RUN.
REQ-009 The block SHALL have port wrap, output, 1, one-cycle pulse on the step that wraps the count.

Function
REQ-010 The block SHALL keep four BCD digits d3..d0, each 0-9: d0 tenths, d1 seconds units, d2 seconds tens, d3 seconds hundreds; 0000 to 9999.
REQ-011 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-012 IDLE SHALL go to RUN on go; RUN SHALL go to PAUSE on go; PAUSE SHALL go to RUN on go.
REQ-013 Any state SHALL go to IDLE on clr, with digits forced to 0000 and the prescaler forced to 0 on the same edge.
REQ-014 When clr and go are high in the same cycle, clr SHALL win and go SHALL be ignored.
REQ-015 Prescaler behaviour SHALL be: 0..TICK_DIV-1 counter; counts only in RUN; holds its value in PAUSE; held at 0 in IDLE.
REQ-016 In RUN, the cycle with prescaler == TICK_DIV-1 SHALL be a step cycle; on that edge the prescaler SHALL return to 0 and the digits SHALL step once.
REQ-017 An up step SHALL add 1 with BCD ripple carry; each digit 9 SHALL become 0 and carry to the next digit.
REQ-018 A down step SHALL subtract 1 with BCD borrow; each digit 0 SHALL become 9 and borrow from the next digit.
REQ-019 Wrap-around SHALL be: up from 9999 gives 0000; down from 0000 gives 9999; wrap SHALL be high for exactly the cycle after that step edge; counting SHALL continue (no stop).
REQ-020 A go pulse that coincides with a step cycle SHALL let the step complete and still apply the go transition.
REQ-021 The first step after IDLE to RUN SHALL occur TICK_DIV cycles after the go edge.
REQ-022 sseg0..sseg3 SHALL be registered, one cycle after the digit change.
REQ-023 Digit encoding (bits6..0) SHALL be: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h.
REQ-024 The dp bit SHALL be 0 (lit) on sseg1 only and 1 on sseg0, sseg2 and sseg3, so the display reads "SSS.t".
REQ-025 running SHALL be a registered decode of state RUN.

Reset
REQ-026 On rst the block SHALL asynchronously enter IDLE and clear digits, prescaler, wrap and running to 0.
REQ-027 On rst the outputs SHALL become sseg0 = C0h, sseg1 = 40h, sseg2 = C0h, sseg3 = C0h, or the blank values of REQ-029 when that macro is defined.
REQ-028 rst asserted mid-count SHALL abandon the count; after release the block SHALL wait in IDLE for go.

Configuration
REQ-029 With macro SSEG_LEAD_BLANK_EN defined, leading zeros on d3 and d2 SHALL be blanked (FFh): d3 blank when d3 = 0; d2 blank when d3 = 0 and d2 = 0.
REQ-030 d1 and d0 SHALL never be blanked.
REQ-031 Without SSEG_LEAD_BLANK_EN, all four digits SHALL always be shown and the blanking logic SHALL be absent.

Verification (TICK_DIV = 4)
REQ-032 Bench SHALL drive rst, then release -> sseg0..3 = C0h, 40h, C0h, C0h (or C0h, 40h, FFh, FFh with macro); running = 0.
REQ-033 Bench SHALL drive go, up = 1, and run 40 cycles -> 10 steps, digits 0010, sseg1 = 79h, sseg0 = C0h, running = 1.
REQ-034 Bench SHALL drive go (pause), wait 20 cycles, then go again -> digits frozen during the pause; the prescaler resumes from its held value, not 0.
REQ-035 Bench SHALL preload 9999 via up-count, take one more step -> digits 0000 and wrap high exactly one cycle.
REQ-036 From 0000 with up = 0, bench SHALL take one step -> digits 9999, wrap pulse, sseg3 = 90h.
REQ-037 Bench SHALL drive clr and go in the same cycle while in RUN -> IDLE, digits 0000, running = 0, no step until the next go.

Source files
------------

// File: rtl/sseg_stopwatch.sv
// Four-digit BCD stopwatch (SSS.t) with IDLE/RUN/PAUSE control and registered
// active-low seven-segment outputs. Define SSEG_LEAD_BLANK_EN to blank leading zeros on d3/d2.
module sseg_stopwatch #(
    parameter int TICK_DIV = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       clr,
    input  logic       up,
    output logic [7:0] sseg0,
    output logic [7:0] sseg1,
    output logic [7:0] sseg2,
    output logic [7:0] sseg3,
    output logic       running,
    output logic       wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

`ifdef SSEG_LEAD_BLANK_EN
    localparam logic [7:0] RST_S2 = 8'hFF;
    localparam logic [7:0] RST_S3 = 8'hFF;
`else
    localparam logic [7:0] RST_S2 = 8'hC0;
    localparam logic [7:0] RST_S3 = 8'hC0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t          r_state, w_state_nx;
    logic [PW-1:0]   r_presc, w_presc_nx;
    logic [3:0][3:0] r_dig, w_dig_nx;
    logic            w_step, w_carry;
    logic            r_wrap, r_running;
    logic [7:0]      r_sseg0, r_sseg1, r_sseg2, r_sseg3;
    logic [7:0]      w_sseg0, w_sseg1, w_sseg2, w_sseg3;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h40;
            4'd1:    f_seg = 7'h79;
            4'd2:    f_seg = 7'h24;
            4'd3:    f_seg = 7'h30;
            4'd4:    f_seg = 7'h19;
            4'd5:    f_seg = 7'h12;
            4'd6:    f_seg = 7'h02;
            4'd7:    f_seg = 7'h78;
            4'd8:    f_seg = 7'h00;
            4'd9:    f_seg = 7'h10;
            default: f_seg = 7'h7F;
        endcase
    endfunction

    assign w_step = (r_state == RUN) && (r_presc == PMAX);

    // clr overrides go in every state
    always_comb begin
        w_state_nx = r_state;
        if (clr) begin
            w_state_nx = IDLE;
        end else if (go) begin
            case (r_state)
                IDLE:    w_state_nx = RUN;
                RUN:     w_state_nx = PAUSE;
                PAUSE:   w_state_nx = RUN;
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        w_presc_nx = r_presc;
        if (clr || r_state == IDLE) begin
            w_presc_nx = '0;
        end else if (r_state == RUN) begin
            w_presc_nx = w_step ? '0 : r_presc + PW'(1);
        end
    end

    // BCD ripple: carry/borrow propagates while a digit wraps at its end value
    always_comb begin
        w_dig_nx = r_dig;
        w_carry  = 1'b0;
        if (w_step) begin
            w_carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (w_carry) begin
                    if (up) begin
                        if (r_dig[i] == 4'd9) begin
                            w_dig_nx[i] = 4'd0;
                        end else begin
                            w_dig_nx[i] = r_dig[i] + 4'd1;
                            w_carry     = 1'b0;
                        end
                    end else begin
                        if (r_dig[i] == 4'd0) begin
                            w_dig_nx[i] = 4'd9;
                        end else begin
                            w_dig_nx[i] = r_dig[i] - 4'd1;
                            w_carry     = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_dig     <= '0;
            r_wrap    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_presc   <= w_presc_nx;
            r_dig     <= clr ? '0 : w_dig_nx;
            r_wrap    <= ~clr & w_carry;
            r_running <= (w_state_nx == RUN);
        end
    end

    // dp lit only on digit 1 so the display reads SSS.t
    always_comb begin
        w_sseg0 = {1'b1, f_seg(r_dig[0])};
        w_sseg1 = {1'b0, f_seg(r_dig[1])};
        w_sseg2 = {1'b1, f_seg(r_dig[2])};
        w_sseg3 = {1'b1, f_seg(r_dig[3])};
`ifdef SSEG_LEAD_BLANK_EN
        if (r_dig[3] == 4'd0) begin
            w_sseg3 = 8'hFF;
            if (r_dig[2] == 4'd0) w_sseg2 = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sseg0 <= 8'hC0;
            r_sseg1 <= 8'h40;
            r_sseg2 <= RST_S2;
            r_sseg3 <= RST_S3;
        end else begin
            r_sseg0 <= w_sseg0;
            r_sseg1 <= w_sseg1;
            r_sseg2 <= w_sseg2;
            r_sseg3 <= w_sseg3;
        end
    end

    assign sseg0   = r_sseg0;
    assign sseg1   = r_sseg1;
    assign sseg2   = r_sseg2;
    assign sseg3   = r_sseg3;
    assign running = r_running;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_sseg_stopwatch.sv
// Bench for sseg_stopwatch: integer-count reference model checked every cycle,
// plus directed checkpoints with hand-computed display values.
module tb_sseg_stopwatch;

    localparam int TICK = 4;

`ifdef SSEG_LEAD_BLANK_EN
    localparam logic [7:0] Z2 = 8'hFF;
    localparam logic [7:0] Z3 = 8'hFF;
`else
    localparam logic [7:0] Z2 = 8'hC0;
    localparam logic [7:0] Z3 = 8'hC0;
`endif

    logic       clk = 1'b0;
    logic       rst, go, clr, up;
    logic [7:0] sseg0, sseg1, sseg2, sseg3;
    logic       running, wrap;

    sseg_stopwatch #(.TICK_DIV(TICK)) dut (
        .clk(clk), .rst(rst), .go(go), .clr(clr), .up(up),
        .sseg0(sseg0), .sseg1(sseg1), .sseg2(sseg2), .sseg3(sseg3),
        .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // reference model: elapsed count as a plain integer 0..9999
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
    int m_state, m_pre, m_cnt, m_cnt_d;
    bit m_wrap;
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= M_IDLE; m_pre <= 0; m_cnt <= 0; m_cnt_d <= 0; m_wrap <= 1'b0;
        end else begin
            m_cnt_d <= m_cnt;
            m_wrap  <= 1'b0;
            if (clr) begin
                m_state <= M_IDLE; m_pre <= 0; m_cnt <= 0;
            end else begin
                if (m_state == M_RUN) begin
                    if (m_pre == TICK - 1) begin
                        m_pre  <= 0;
                        m_cnt  <= up ? (m_cnt + 1) % 10000 : (m_cnt + 9999) % 10000;
                        m_wrap <= up ? (m_cnt == 9999) : (m_cnt == 0);
                    end else begin
                        m_pre <= m_pre + 1;
                    end
                end
                if (go) m_state <= (m_state == M_RUN) ? M_PAUSE : M_RUN;
            end
        end
    end

    function automatic logic [7:0] exp_seg(input int k, input int cnt);
        int d;
        d = cnt;
        for (int i = 0; i < k; i++) d = d / 10;
        d = d % 10;
        exp_seg = {(k == 1) ? 1'b0 : 1'b1, seg_tab[d]};
`ifdef SSEG_LEAD_BLANK_EN
        if (k == 3 && cnt < 1000) exp_seg = 8'hFF;
        if (k == 2 && cnt < 100)  exp_seg = 8'hFF;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && chk_on) begin
            chk("m_sseg0", sseg0, exp_seg(0, m_cnt_d));
            chk("m_sseg1", sseg1, exp_seg(1, m_cnt_d));
            chk("m_sseg2", sseg2, exp_seg(2, m_cnt_d));
            chk("m_sseg3", sseg3, exp_seg(3, m_cnt_d));
            chk("m_running", {7'b0, running}, {7'b0, m_state == M_RUN});
            chk("m_wrap", {7'b0, wrap}, {7'b0, m_wrap});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; go = 1'b0; clr = 1'b0; up = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        chk_on = 1'b1;
        wait_cyc(1);
        chk("rst_sseg0", sseg0, 8'hC0);
        chk("rst_sseg1", sseg1, 8'h40);
        chk("rst_sseg2", sseg2, Z2);
        chk("rst_sseg3", sseg3, Z3);
        chk("rst_running", {7'b0, running}, 8'h00);

        // 10 steps at 4 cycles each, display lags the digits by one cycle
        pulse_go();
        wait_cyc(41);
        chk("run_sseg1", sseg1, 8'h79);
        chk("run_sseg0", sseg0, 8'hC0);
        chk("run_sseg3", sseg3, Z3);
        chk("run_running", {7'b0, running}, 8'h01);

        // pause freezes digits; prescaler held at 2 so the resume step comes 2 edges later
        pulse_go();
        wait_cyc(20);
        chk("pause_sseg1", sseg1, 8'h79);
        chk("pause_sseg0", sseg0, 8'hC0);
        chk("pause_running", {7'b0, running}, 8'h00);
        pulse_go();
        wait_cyc(3);
        chk("resume_sseg0", sseg0, 8'hF9);

        n = 0;
        while (m_cnt != 9999 && n < 50000) begin
            @(negedge clk);
            n++;
        end
        chk("preload_timeout", {7'b0, n < 50000}, 8'h01);
        wait_cyc(4);
        chk("upwrap_wrap", {7'b0, wrap}, 8'h01);
        wait_cyc(1);
        chk("upwrap_wrap_off", {7'b0, wrap}, 8'h00);
        chk("upwrap_sseg0", sseg0, 8'hC0);
        chk("upwrap_sseg1", sseg1, 8'h40);
        chk("upwrap_sseg2", sseg2, Z2);
        chk("upwrap_sseg3", sseg3, Z3);

        up = 1'b0;
        wait_cyc(3);
        chk("dnwrap_wrap", {7'b0, wrap}, 8'h01);
        wait_cyc(1);
        chk("dnwrap_sseg3", sseg3, 8'h90);
        chk("dnwrap_sseg1", sseg1, 8'h10);
        chk("dnwrap_wrap_off", {7'b0, wrap}, 8'h00);
        wait_cyc(9);

        // clr beats a simultaneous go
        clr = 1'b1; go = 1'b1;
        @(negedge clk);
        clr = 1'b0; go = 1'b0;
        chk("clr_running", {7'b0, running}, 8'h00);
        wait_cyc(1);
        chk("clr_sseg0", sseg0, 8'hC0);
        chk("clr_sseg3", sseg3, Z3);
        wait_cyc(12);
        chk("clr_hold_sseg0", sseg0, 8'hC0);
        chk("clr_hold_running", {7'b0, running}, 8'h00);

        up = 1'b1;
        pulse_go();
        wait_cyc(5);
        chk("restart_sseg0", sseg0, 8'hF9);
        wait_cyc(7);

        // asynchronous reset mid-count
        #2 rst = 1'b1;
        #1;
        chk("arst_running", {7'b0, running}, 8'h00);
        chk("arst_sseg0", sseg0, 8'hC0);
        chk("arst_sseg1", sseg1, 8'h40);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(12);
        chk("arst_idle_sseg0", sseg0, 8'hC0);
        chk("arst_idle_running", {7'b0, running}, 8'h00);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
